// File: rtl/mtsp_gpr_pkg.sv
// mtsp_gpr_pkg: shared widths, FSM states and lane-merge helper for the GPR read responder
package mtsp_gpr_pkg;
  localparam int LANE_W = 32;
  localparam int GPR_ADDR_W = 8;
  localparam int GPR_LANES = 4;
  localparam int GPR_DATA_W = LANE_W * GPR_LANES;
  typedef enum logic {INIT, RUN} gpr_state_t;
  function automatic logic [GPR_DATA_W-1:0] lane_merge(
    input logic [GPR_DATA_W-1:0] old_d,
    input logic [GPR_DATA_W-1:0] new_d,
    input logic [GPR_LANES-1:0] mask
  );
    logic [GPR_DATA_W-1:0] r;
    r = old_d;
    for (int i = 0; i < GPR_LANES; i++)
      if (mask[i]) r[i*LANE_W +: LANE_W] = new_d[i*LANE_W +: LANE_W];
    return r;
  endfunction
endpackage

// File: rtl/mtsp_gpr_ram.sv
// mtsp_gpr_ram: 1R1W synchronous read-first RAM with per-lane write mask
module mtsp_gpr_ram
  import mtsp_gpr_pkg::*;
#(
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int LANES = GPR_LANES
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [LANE_W*LANES-1:0]  rdata,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [LANE_W*LANES-1:0]  wdata,
  input  logic [LANES-1:0]         wmask
);
  logic [LANE_W*LANES-1:0] mem [1 << ADDR_W];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < LANES; i++)
      if (we && wmask[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
  end
endmodule

// File: rtl/mtsp_gpr_rd_responder.sv
// mtsp_gpr_rd_responder: GPR bank read responder with clear sweep, two-cycle reads and per-lane write forwarding
module mtsp_gpr_rd_responder
  import mtsp_gpr_pkg::*;
#(
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int LANES = GPR_LANES
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     SRC_nEN,
  input  logic [ADDR_W-1:0]        SRC_ADDR,
  output logic [LANE_W*LANES-1:0]  SRC_DATA,
  output logic                     SRC_VALID,
  input  logic                     WR_nEN,
  input  logic [ADDR_W-1:0]        WR_ADDR,
  input  logic [LANE_W*LANES-1:0]  WR_DATA,
  input  logic [LANES-1:0]         WR_MASK,
  output logic                     READY
);
  localparam int DATA_W = LANE_W * LANES;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
  gpr_state_t state, state_nx;
  logic [ADDR_W:0] cnt, cnt_nx;
  logic init, wr_go, ram_we, s1_valid, s1_zero;
  logic [ADDR_W-1:0] ram_waddr, s1_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q, s1_fwd_data, merged;
  logic [LANES-1:0] ram_wmask, s1_fwd_mask, live_mask;
  assign init = state == INIT;
  assign READY = state == RUN;
  assign wr_go = !WR_nEN && !init;
  assign ram_we = init || wr_go;
  assign ram_waddr = init ? cnt[ADDR_W-1:0] : WR_ADDR;
  assign ram_wdata = init ? '0 : WR_DATA;
  assign ram_wmask = init ? '1 : WR_MASK;
  always_comb begin
    state_nx = (init && cnt == LAST) ? RUN : state;
    cnt_nx = init ? cnt + 1'b1 : cnt;
  end
  mtsp_gpr_ram #(.ADDR_W(ADDR_W), .LANES(LANES)) u_ram (
    .clk(CLK), .re(!SRC_nEN), .raddr(SRC_ADDR), .rdata(ram_q),
    .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata), .wmask(ram_wmask)
  );
  // the write sampled with the read was missed by the read-first RAM; the live write overrides it
  assign live_mask = (wr_go && WR_ADDR == s1_addr) ? WR_MASK : '0;
  assign merged = lane_merge(lane_merge(ram_q, s1_fwd_data, s1_fwd_mask), WR_DATA, live_mask);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= INIT;
      cnt <= '0;
      s1_valid <= 1'b0;
      s1_zero <= 1'b0;
      s1_addr <= '0;
      s1_fwd_mask <= '0;
      s1_fwd_data <= '0;
      SRC_VALID <= 1'b0;
      SRC_DATA <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      s1_valid <= !SRC_nEN;
      s1_zero <= init;
      s1_addr <= SRC_ADDR;
      s1_fwd_mask <= (wr_go && WR_ADDR == SRC_ADDR) ? WR_MASK : '0;
      s1_fwd_data <= WR_DATA;
      SRC_VALID <= s1_valid;
      if (s1_valid) SRC_DATA <= s1_zero ? '0 : merged;
    end
  end
endmodule

// File: tb/tb_mtsp_gpr_rd_responder.sv
// tb_mtsp_gpr_rd_responder: directed self-checking bench for the GPR read responder
module tb_mtsp_gpr_rd_responder;
  logic CLK = 0, nRST = 0, SRC_nEN = 1, WR_nEN = 1, SRC_VALID, READY;
  logic [7:0] SRC_ADDR = '0, WR_ADDR = '0;
  logic [127:0] SRC_DATA, WR_DATA = '0;
  logic [3:0] WR_MASK = '0;
  logic [127:0] model [256];
  logic req_v [265];
  logic [7:0] req_a [265];
  logic [7:0] bub = 8'b1011_0010;
  int checks = 0, errors = 0;
  mtsp_gpr_rd_responder dut (
    .CLK(CLK), .nRST(nRST), .SRC_nEN(SRC_nEN), .SRC_ADDR(SRC_ADDR), .SRC_DATA(SRC_DATA),
    .SRC_VALID(SRC_VALID), .WR_nEN(WR_nEN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_MASK(WR_MASK), .READY(READY)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [127:0] d, input logic [3:0] m);
    WR_nEN = 0; WR_ADDR = a; WR_DATA = d; WR_MASK = m;
  endtask
  task automatic rd(input logic [7:0] a);
    SRC_nEN = 0; SRC_ADDR = a;
  endtask
  function automatic logic [127:0] pat(input int a);
    return {32'(a) + 32'h3000_0000, 32'(a) + 32'h2000_0000, 32'(a) + 32'h1000_0000, 32'(a)};
  endfunction
  initial begin
    tick;
    tick;
    check("rst_valid", SRC_VALID, 0);
    check("rst_ready", READY, 0);
    check("rst_data", SRC_DATA, 0);
    nRST = 1;
    repeat (10) tick;
    rd(8'h37);
    tick;
    SRC_nEN = 1;
    tick;
    check("init_rd_valid", SRC_VALID, 1);
    check("init_rd_data", SRC_DATA, 0);
    check("init_ready", READY, 0);
    tick;
    check("init_idle_valid", SRC_VALID, 0);
    repeat (7) tick;
    wr(8'h05, '1, 4'hF);
    tick;
    WR_nEN = 1;
    repeat (234) tick;
    check("ready_255", READY, 0);
    tick;
    check("ready_256", READY, 1);
    for (int i = 0; i < 256; i++) model[i] = '0;
    wr(8'h37, 128'h4444_3333_2222_1111, 4'hF);
    tick;
    WR_nEN = 1;
    rd(8'h37);
    tick;
    SRC_nEN = 1;
    tick;
    check("basic_rd", SRC_DATA, 128'h4444_3333_2222_1111);
    rd(8'h05);
    tick;
    SRC_nEN = 1;
    tick;
    check("init_wr_drop", SRC_DATA, 0);
    wr(8'h10, {4{32'hAAAA_AAAA}}, 4'hF);
    tick;
    WR_nEN = 1;
    tick;
    rd(8'h10);
    wr(8'h10, {4{32'h5555_5555}}, 4'b0101);
    tick;
    SRC_nEN = 1;
    WR_nEN = 1;
    tick;
    check("same_cycle_fwd", SRC_DATA, 128'hAAAAAAAA_55555555_AAAAAAAA_55555555);
    rd(8'h10);
    tick;
    SRC_nEN = 1;
    tick;
    check("same_cycle_commit", SRC_DATA, 128'hAAAAAAAA_55555555_AAAAAAAA_55555555);
    rd(8'h10);
    wr(8'h10, 128'h13131313_12121212_11111111_10101010, 4'hF);
    tick;
    SRC_nEN = 1;
    wr(8'h10, {4{32'hDEAD_BEEF}}, 4'h1);
    tick;
    WR_nEN = 1;
    check("next_cycle_fwd_prio", SRC_DATA, 128'h13131313_12121212_11111111_DEADBEEF);
    rd(8'h10);
    tick;
    SRC_nEN = 1;
    tick;
    check("next_cycle_commit", SRC_DATA, 128'h13131313_12121212_11111111_DEADBEEF);
    for (int a = 0; a < 256; a++) begin
      wr(8'(a), pat(a), 4'hF);
      model[a] = pat(a);
      tick;
    end
    wr(8'h21, '1, 4'h0);
    tick;
    WR_nEN = 1;
    for (int c = 0; c < 265; c++) begin
      if (c < 256) begin
        req_v[c] = 1; req_a[c] = 8'(c);
      end else if (c < 264) begin
        req_v[c] = bub[c-256]; req_a[c] = 8'(8'h1C + c - 256);
      end else begin
        req_v[c] = 0; req_a[c] = '0;
      end
      SRC_nEN = !req_v[c];
      SRC_ADDR = req_a[c];
      tick;
      if (c >= 1) begin
        check("stream_valid", SRC_VALID, req_v[c-1]);
        if (req_v[c-1]) check("stream_data", SRC_DATA, model[req_a[c-1]]);
      end
    end
    SRC_nEN = 1;
    tick;
    check("stream_tail_valid", SRC_VALID, req_v[264]);
    rd(8'h01);
    tick;
    rd(8'h02);
    tick;
    check("pre_rst_valid", SRC_VALID, 1);
    nRST = 0;
    SRC_nEN = 1;
    #1;
    check("mid_rst_valid", SRC_VALID, 0);
    check("mid_rst_ready", READY, 0);
    tick;
    check("mid_rst_hold_valid", SRC_VALID, 0);
    nRST = 1;
    repeat (255) tick;
    check("rerun_ready_255", READY, 0);
    tick;
    check("rerun_ready_256", READY, 1);
    rd(8'h01);
    tick;
    rd(8'h37);
    tick;
    SRC_nEN = 1;
    check("rerun_rd1_valid", SRC_VALID, 1);
    check("rerun_rd1_data", SRC_DATA, 0);
    tick;
    check("rerun_rd37_data", SRC_DATA, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
